note_recorder: RTL and testbench
================================

Name: note_recorder

Overview:
- Parametrised record/playback engine for the mini piano; a successor to the fixed 7-key free-play path.
- In IDLE it passes live keys straight through to the tone stage, as free play does today.
- In REC it time-stamps key activity into an on-chip event buffer.
- In PLAY it replays the buffer, optionally looping, and drives the same note/octave interface the Buzzer consumes.

Parameters:
- N_KEYS, 7, number of piano keys (1..15; note codes 1..N_KEYS).
- OCT_W, 2, octave field width.
- DEPTH, 64, event buffer entries (power of two).
- DUR_W, 8, duration field width, in ticks.
- TICK_DIV, 5000000, clk cycles per tick (50 ms at 100 MHz).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- keys, input, N_KEYS, key levels; bit i = note code i+1.
- octave, input, OCT_W, live octave selection.
- rec_start, input, 1, single-cycle pulse: begin recording (overwrites buffer).
- play_start, input, 1, single-cycle pulse: begin playback from entry 0.
- stop, input, 1, single-cycle pulse: end REC or PLAY.
- loop_en, input, 1, playback wraps to entry 0 instead of ending.
- note_out, output, 4, 0 = rest, k = key k.
- octave_out, output, OCT_W, octave for note_out.
- state_out, output, 2, 0 IDLE, 1 REC, 2 PLAY.
- count, output, $clog2(DEPTH)+1, number of stored events.
- full, output, 1, count == DEPTH.
- led_out, output, N_KEYS, one-hot of the current note_out (0 when resting).

Behaviour:
- Reset (async, active-high): state IDLE; note_out 0; octave_out 0; count 0; full 0; led_out 0; tick counter 0. Buffer contents are don't-care.
- Command priority in a single cycle: stop > rec_start > play_start. Commands not valid in the current state are ignored, except stop.
- Key encode: the lowest-index pressed key wins. No key pressed gives code 0 (rest).
- Tick: the tick_gen counter runs 0..TICK_DIV-1 and pulses on the final count. It clears on every state entry, so the first tick comes TICK_DIV cycles after entry.
- IDLE:
  - note_out/octave_out are registered from live keys/octave, 1-cycle latency.
- REC entry:
  - count <= 0, full <= 0.
  - The held event is loaded from the current keys/octave with dur = 1.
- REC, on each tick:
  - If the sampled note/octave equals the held event and dur < 2^DUR_W-1: dur++.
  - Otherwise, commit the held event {note, octave, dur} at buffer[count], count++, then load the new sample with dur = 1.
  - Saturated duration splits into consecutive entries of the same note.
  - Leading rests are not recorded: while count == 0 and the held note is 0, the held event is overwritten rather than committed.
  - note_out follows live keys during REC.
- REC, commit that makes count == DEPTH: full <= 1, state -> IDLE the next cycle. The event in progress is discarded.
- REC, stop: commit the held event if its note != 0 and the buffer is not full, then go to IDLE. A trailing rest is dropped.
- PLAY entry:
  - Ignored if count == 0 (stays IDLE).
  - Otherwise idx <= 0. The buffer has synchronous read, so note_out/octave_out show entry 0 two cycles after the play_start pulse.
- PLAY, per entry: hold the output for dur ticks. On the final tick, advance idx.
  - If idx == count-1 and loop_en = 1: wrap to 0.
  - If idx == count-1 and loop_en = 0: go to IDLE and output live keys the next cycle.
  - loop_en is sampled at each wrap decision.
- PLAY, stop: return to IDLE immediately. note_out reflects live keys 1 cycle later.
- rec_start during PLAY and play_start during REC are ignored.
- led_out is combinationally decoded from registered note_out.
- Buffer entry width: 4 + OCT_W + DUR_W. Implement as a register array or inferred RAM; no reset on the array.

Decomposition:
- Shared package piano_pkg:
  - state encoding ST_IDLE/ST_REC/ST_PLAY.
  - NOTE_REST = 0.
  - note-code width 4.
  - event record typedef {note, octave, dur}.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset, clr, tick).

Test Plan:
All tests use TICK_DIV=4, DEPTH=4, DUR_W=3.
1. Reset mid-PLAY: assert reset asynchronously -> same cycle: state_out=0, note_out=0, count=0, led_out=0.
2. Record then stop: rec_start, hold keys=0000100 for 3 ticks, keys=0000001 for 2 ticks, stop -> count=2; entries {3,oct,3} and {1,oct,2}.
3. Playback: play_start with loop_en=0 -> note_out=3 appears 2 cycles after the pulse and holds 12 cycles; note_out=1 holds 8 cycles; then IDLE, and note_out tracks keys.
4. Duration saturation: hold one key for 9 ticks, then stop -> entries dur=7 and dur=2, count=2.
5. Full: 5 alternating notes of 1 tick each -> full=1 and state_out=0 after the 4th commit, count=4; the 5th note is not stored.
6. Priority/loop: stop+rec_start in the same cycle during PLAY -> IDLE; play_start with count=0 -> stays IDLE; loop_en=1 with count=2 -> entry 0 replays after entry 1.

Source files
------------

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared types and helpers for the piano record/playback path
// Contents: recorder state encoding, note-code width and rest code, and the
//           lowest-key-wins key encoder used by the live and record paths.
package piano_pkg;

    localparam int NOTE_W   = 4;
    localparam int MAX_KEYS = 15;

    typedef logic [NOTE_W-1:0] note_t;

    localparam note_t NOTE_REST = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    // Lowest-index pressed key wins; no key pressed is a rest.
    function automatic note_t encode_keys(input logic [MAX_KEYS-1:0] k);
        note_t n;
        n = NOTE_REST;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (k[i]) n = note_t'(i + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/note_recorder_tick_gen.sv
// rtl/note_recorder_tick_gen.sv - free-running tick divider with synchronous clear
// Ports: clk, reset (async, active-high), clr (restart count at 0),
//        tick (high on the final count TICK_DIV-1, suppressed while clr).
module tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - record/playback engine for the mini piano tone stage
// Ports: clk, reset (async, active-high); keys/octave live inputs;
//        rec_start/play_start/stop command pulses, loop_en playback wrap;
//        note_out/octave_out to the tone stage, state_out, count, full,
//        led_out (one-hot of note_out).
module note_recorder #(
    parameter int N_KEYS   = 7,
    parameter int OCT_W    = 2,
    parameter int DEPTH    = 64,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 5000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_KEYS-1:0]        keys,
    input  logic [OCT_W-1:0]         octave,
    input  logic                     rec_start,
    input  logic                     play_start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [3:0]               note_out,
    output logic [OCT_W-1:0]         octave_out,
    output logic [1:0]               state_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [N_KEYS-1:0]        led_out
);
    import piano_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEPTH - 1);
    localparam logic [DUR_W-1:0] DUR_MAX  = '1;
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

    typedef struct packed {
        note_t             note;
        logic [OCT_W-1:0]  oct;
        logic [DUR_W-1:0]  dur;
    } event_t;

    state_t           r_state;
    event_t           r_mem [DEPTH];
    event_t           r_hold;
    event_t           r_rd;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_idx;
    logic [DUR_W-1:0] r_pdur;

    note_t            w_note;
    event_t           w_sample;
    logic             w_tick, w_clr, w_rec_go, w_play_go;
    logic             w_extend, w_drop, w_we, w_last, w_pend;
    logic [AW-1:0]    w_raddr;

    assign w_note = encode_keys(MAX_KEYS'(keys));

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_comb begin
        w_sample      = '0;
        w_sample.note = w_note;
        w_sample.oct  = octave;
        w_sample.dur  = DUR_ONE;

        // stop outranks rec_start, which outranks play_start
        w_rec_go  = !stop && rec_start && r_state == ST_IDLE;
        w_play_go = !stop && !rec_start && play_start && r_state == ST_IDLE && r_count != '0;
        w_clr     = (stop && r_state != ST_IDLE) || w_rec_go || w_play_go;

        w_extend = w_sample.note == r_hold.note && w_sample.oct == r_hold.oct && r_hold.dur != DUR_MAX;
        // a rest held before anything is stored is replaced, never committed
        w_drop   = r_count == '0 && r_hold.note == NOTE_REST;

        w_we = 1'b0;
        if (r_state == ST_REC && !stop && w_tick && !w_extend && !w_drop) w_we = 1'b1;
        if (r_state == ST_REC && stop && r_hold.note != NOTE_REST && r_count != CNT_FULL) w_we = 1'b1;

        w_last = r_idx == AW'(r_count - 1'b1);
        w_pend = r_state == ST_PLAY && !stop && w_tick && r_pdur == r_rd.dur - 1'b1;

        // read address runs one step ahead so the entry is ready when idx moves
        w_raddr = r_idx;
        if (w_play_go)   w_raddr = '0;
        else if (w_pend) w_raddr = w_last ? '0 : r_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_count[AW-1:0]] <= r_hold;
        r_rd <= r_mem[w_raddr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            note_out   <= NOTE_REST;
            octave_out <= '0;
            r_count    <= '0;
            full       <= 1'b0;
            r_hold     <= '0;
            r_idx      <= '0;
            r_pdur     <= '0;
        end else begin
            if (r_state == ST_PLAY) begin
                note_out   <= r_rd.note;
                octave_out <= r_rd.oct;
            end else begin
                note_out   <= w_note;
                octave_out <= octave;
            end

            if (w_we) r_count <= r_count + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_rec_go) begin
                        r_state <= ST_REC;
                        r_count <= '0;
                        full    <= 1'b0;
                        r_hold  <= w_sample;
                    end else if (w_play_go) begin
                        r_state <= ST_PLAY;
                        r_idx   <= '0;
                        r_pdur  <= '0;
                    end
                end
                ST_REC: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        if (w_extend) begin
                            r_hold.dur <= r_hold.dur + 1'b1;
                        end else begin
                            r_hold <= w_sample;
                            if (!w_drop && r_count == CNT_LAST) begin
                                full    <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_pend) begin
                        r_pdur <= '0;
                        if (!w_last)     r_idx   <= r_idx + 1'b1;
                        else if (loop_en) r_idx  <= '0;
                        else             r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        r_pdur <= r_pdur + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign state_out = r_state;
    assign count     = r_count;

    always_comb begin
        led_out = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (note_out == note_t'(i + 1)) led_out[i] = 1'b1;
        end
    end

endmodule

// File: tb/tb_note_recorder.sv
// tb/tb_note_recorder.sv - self-checking bench for note_recorder
module tb_note_recorder;

    localparam int TD = 4;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] keys = '0;
    logic [1:0] octave = '0;
    logic       rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [3:0] note_out;
    logic [1:0] octave_out, state_out;
    logic [2:0] count;
    logic       full;
    logic [6:0] led_out;

    int n_checks = 0;
    int n_pass = 0;

    logic [6:0] s_keys[$];
    logic [1:0] s_oct[$];
    int ev_note[$], ev_oct[$], ev_dur[$];
    bit m_full;

    note_recorder #(.N_KEYS(7), .OCT_W(2), .DEPTH(DP), .DUR_W(3), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .keys(keys), .octave(octave),
        .rec_start(rec_start), .play_start(play_start), .stop(stop), .loop_en(loop_en),
        .note_out(note_out), .octave_out(octave_out), .state_out(state_out),
        .count(count), .full(full), .led_out(led_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int enc(input logic [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
        return 0;
    endfunction

    function automatic int led_of(input int n);
        return (n == 0) ? 0 : (1 << (n - 1));
    endfunction

    // Run-length encode the per-tick samples: saturating durations, leading
    // rests dropped, stop keeps a non-rest held event, DEPTH entries max.
    task automatic model_record(input int n);
        int hn, ho, hd;
        ev_note.delete(); ev_oct.delete(); ev_dur.delete();
        m_full = 0;
        hn = enc(s_keys[0]); ho = int'(s_oct[0]); hd = 1;
        for (int k = 1; k < n; k++) begin
            int sn, so;
            sn = enc(s_keys[k]); so = int'(s_oct[k]);
            if (sn == hn && so == ho && hd < 7) begin
                hd++;
            end else begin
                if (!(ev_note.size() == 0 && hn == 0)) begin
                    ev_note.push_back(hn); ev_oct.push_back(ho); ev_dur.push_back(hd);
                    if (ev_note.size() == DP) begin m_full = 1; break; end
                end
                hn = sn; ho = so; hd = 1;
            end
        end
        if (!m_full && hn != 0) begin
            ev_note.push_back(hn); ev_oct.push_back(ho); ev_dur.push_back(hd);
        end
    endtask

    task automatic record(input int n, input bit do_stop);
        keys = s_keys[0]; octave = s_oct[0]; rec_start = 1'b1;
        step();
        rec_start = 1'b0;
        check("rec_entry_state", int'(state_out), 1);
        check("rec_live0", int'(note_out), enc(s_keys[0]));
        for (int k = 1; k < n; k++) begin
            keys = s_keys[k]; octave = s_oct[k];
            repeat (TD) step();
            check("rec_live", int'(note_out), enc(s_keys[k]));
        end
        if (do_stop) begin
            stop = 1'b1; step(); stop = 1'b0;
        end
    endtask

    task automatic check_record_result(input string tag);
        check({tag, "_count"}, int'(count), ev_note.size());
        check({tag, "_full"}, int'(full), int'(m_full));
        check({tag, "_state"}, int'(state_out), 0);
    endtask

    task automatic play_check(input bit lp, input int extra);
        keys = 7'($urandom); octave = 2'($urandom); loop_en = lp;
        play_start = 1'b1; step(); play_start = 1'b0; step();
        check("play_state", int'(state_out), 2);
        for (int e = 0; e < ev_note.size(); e++) begin
            for (int c = 0; c < ev_dur[e] * TD; c++) begin
                check($sformatf("play_e%0d_c%0d", e, c), int'({note_out, octave_out}), ev_note[e] * 4 + ev_oct[e]);
                check("play_led", int'(led_out), led_of(ev_note[e]));
                step();
            end
        end
        if (!lp) begin
            check("play_end_state", int'(state_out), 0);
            check("play_end_live", int'({note_out, octave_out}), enc(keys) * 4 + int'(octave));
        end else begin
            for (int c = 0; c < extra; c++) begin
                check($sformatf("loop_e0_c%0d", c), int'({note_out, octave_out}), ev_note[0] * 4 + ev_oct[0]);
                step();
            end
            stop = 1'b1; step(); stop = 1'b0;
            check("loop_stop_state", int'(state_out), 0);
            step();
            check("loop_stop_live", int'({note_out, octave_out}), enc(keys) * 4 + int'(octave));
        end
    endtask

    task automatic load(input logic [6:0] kq[$], input logic [1:0] oc);
        s_keys.delete(); s_oct.delete();
        foreach (kq[i]) begin s_keys.push_back(kq[i]); s_oct.push_back(oc); end
    endtask

    initial begin
        logic [6:0] kq[$];
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state_out), 0);
        check("rst_note", int'(note_out), 0);
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        check("rst_led", int'(led_out), 0);
        reset = 1'b0;
        step();

        // free play in IDLE
        keys = 7'b0101000; octave = 2'd3; step();
        check("idle_live", int'({note_out, octave_out}), 4 * 4 + 3);
        check("idle_led", int'(led_out), 7'b0001000);

        // two notes then stop
        kq = '{7'b0000100, 7'b0000100, 7'b0000100, 7'b0000001, 7'b0000001};
        load(kq, 2'd2); record(5, 1'b1); model_record(5);
        check("rec2_count_abs", int'(count), 2);
        check_record_result("rec2");
        play_check(1'b0, 0);

        // duration saturation
        kq = '{7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000,
               7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000};
        load(kq, 2'd1); record(9, 1'b1); model_record(9);
        check("sat_count_abs", int'(count), 2);
        check_record_result("sat");
        play_check(1'b0, 0);

        // buffer fills on the 4th commit and ends recording by itself
        kq = '{7'b0000001, 7'b0000010, 7'b0000001, 7'b0000010, 7'b0000001};
        load(kq, 2'd0); record(5, 1'b0); model_record(5);
        check("full_flag_abs", int'(full), 1);
        check_record_result("full");
        play_check(1'b0, 0);

        // stop + rec_start while playing
        loop_en = 1'b0; play_start = 1'b1; step(); play_start = 1'b0;
        repeat (3) step();
        stop = 1'b1; rec_start = 1'b1; step(); stop = 1'b0; rec_start = 1'b0;
        check("prio_stop_state", int'(state_out), 0);
        check("prio_stop_count", int'(count), 4);

        // rec_start beats play_start in IDLE
        rec_start = 1'b1; play_start = 1'b1; step(); rec_start = 1'b0; play_start = 1'b0;
        check("prio_rec_state", int'(state_out), 1);
        stop = 1'b1; step(); stop = 1'b0;

        // rests only: nothing stored, play_start ignored
        kq = '{7'b0, 7'b0, 7'b0};
        load(kq, 2'd1); record(3, 1'b1); model_record(3);
        check_record_result("rest");
        play_start = 1'b1; step(); play_start = 1'b0;
        check("empty_play_state", int'(state_out), 0);
        step();
        check("empty_play_state2", int'(state_out), 0);

        // looped playback
        kq = '{7'b0000001, 7'b0000001, 7'b0001000};
        load(kq, 2'd3); record(3, 1'b1); model_record(3);
        check_record_result("loop");
        play_check(1'b1, 5);

        // randomized recordings
        for (int it = 0; it < 6; it++) begin
            int n;
            logic [6:0] pk;
            logic [1:0] po;
            n = $urandom_range(2, 9);
            s_keys.delete(); s_oct.delete();
            pk = '0; po = '0;
            for (int k = 0; k < n; k++) begin
                if (k == 0 || $urandom_range(0, 1) == 0) begin
                    pk = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
                end
                if (k == 0 || $urandom_range(0, 3) == 0) po = 2'($urandom);
                s_keys.push_back(pk); s_oct.push_back(po);
            end
            record(n, 1'b1); model_record(n);
            check_record_result($sformatf("rnd%0d", it));
            if (ev_note.size() > 0) play_check(1'b0, 0);
        end

        // asynchronous reset in the middle of playback
        kq = '{7'b0000010, 7'b0000010};
        load(kq, 2'd1); record(2, 1'b1); model_record(2);
        check_record_result("pre_rst");
        play_start = 1'b1; step(); play_start = 1'b0;
        repeat (3) step();
        check("pre_rst_play", int'(state_out), 2);
        reset = 1'b1;
        #1;
        check("arst_state", int'(state_out), 0);
        check("arst_note", int'(note_out), 0);
        check("arst_count", int'(count), 0);
        check("arst_led", int'(led_out), 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_state", int'(state_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
